ubuf_stream_bank: RTL and testbench
===================================

// Module: ubuf_stream_bank
// PURPOSE
//  Parametrised unified-buffer bank: DEPTH rows x ROW_W bits, ROW_W = CH_MAX*LANES*ELEM_W, split into CH_MAX slots.
//  Three ports: AXI word read/write with byte strobes; VPU multi-slot write with valid/ready backpressure;
//  and a strided streaming read engine (valid/ready) feeding the systolic array one slot per beat.
//  Next-generation input-store bank: replaces hard-coded 16x8b/4-channel sizing and fire-and-forget ports.
// PARAMETERS
//  LANES      16       elements per slot (SA columns)
//  ELEM_W     8        bits per element
//  CH_MAX     4        slots per row (power of 2, >=4)
//  DEPTH      256      rows (power of 2)
//  AXI_DW     64       AXI data width; must divide ROW_W
//  AXI_AW     16       AXI address width (word address)
//  BASE_ADDR  16'h2000 first AXI word address of this bank
//  Derived: SLOT_W=LANES*ELEM_W; WPR=ROW_W/AXI_DW; SA_W=$clog2(DEPTH*CH_MAX) (slot address = row*CH_MAX+slot)
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             async reset, active low
//  axi_en       in   1             AXI access strobe
//  axi_we       in   1             1=write, 0=read
//  axi_addr     in   AXI_AW        word address
//  axi_wdata    in   AXI_DW        write data
//  axi_wstrb    in   AXI_DW/8      byte enables
//  axi_rdata    out  AXI_DW        read data (registered)
//  axi_rvalid   out  1             rdata valid pulse
//  vpu_wr_valid in   1             VPU write request
//  vpu_wr_ready out  1             VPU write accepted this cycle
//  vpu_wr_addr  in   SA_W          slot address
//  vpu_wr_size  in   2             01=1 slot, 10=2 slots, 11=4 slots, 00=no-op
//  vpu_wr_data  in   CH_MAX*SLOT_W channel c at [c*SLOT_W +: SLOT_W]
//  str_start    in   1             start stream (honoured only when idle)
//  str_base     in   SA_W          first slot address
//  str_len      in   16            beat count
//  str_stride   in   SA_W          slot-address increment per beat
//  str_busy     out  1             engine not idle
//  str_done     out  1             1-cycle pulse at stream end
//  str_valid    out  1             beat valid
//  str_ready    in   1             consumer ready
//  str_data     out  SLOT_W        beat data
//  str_last     out  1             final beat marker
// BEHAVIOUR
//  Reset (rst_n low, async): axi_rdata=0, axi_rvalid=0, vpu_wr_ready=0, str_busy/done/valid/last=0, str_data=0,
//   FSM->IDLE; any in-flight stream is abandoned. Memory contents are NOT cleared and survive reset.
//  Slot layout: slot s of row r = bits [s*SLOT_W +: SLOT_W]; lane l in slot = [(LANES-1-l)*ELEM_W +: ELEM_W].
//  AXI: hit = BASE_ADDR <= axi_addr < BASE_ADDR+DEPTH*WPR; off=axi_addr-BASE_ADDR; row=off/WPR; word=off%WPR.
//   Write: byte b written iff axi_wstrb[b]; miss ignored. Read (en&!we): axi_rvalid=1 next cycle, rdata=word, 0 on miss.
//  VPU write: vpu_wr_ready = rst_n & !(axi_en & axi_we & hit) (AXI write has priority, whole cycle). Accepted on valid&ready.
//   n=1/2/4 slots; base slot = vpu_wr_addr with low log2(n) bits cleared; channel c -> slot base+n-1-c,
//   channels >=n unused. Size 00: handshake completes, nothing written.
//  Same-cycle read/write to same location (any ports): read returns OLD data.
//  Stream FSM IDLE/RUN:
//   IDLE: str_start & str_len==0 -> str_done pulse next cycle, stay IDLE.
//         str_start & str_len!=0 -> capture mem[str_base] into str_data, str_valid=1, str_last=(len==1),
//         ptr=str_base+stride, remaining=len-1, go RUN; str_busy=1 from next cycle.
//   RUN: beat advances when str_valid & str_ready; if remaining!=0 capture mem[ptr], ptr+=stride, remaining--;
//        str_data/valid/last held stable while str_ready=0.
//        Last beat accepted -> str_valid=0, str_done=1 for one cycle, str_busy=0, IDLE.
//   str_start while RUN ignored. Pointer wraps modulo DEPTH*CH_MAX. Zero-bubble: 1 beat/cycle with str_ready high.
//  Latency: AXI read 1 cycle; stream first beat valid 1 cycle after start; write visible to reads next cycle.
// TESTING
//  AXI write 0x1122334455667788 @0x2000 strb=0xFF, read -> rvalid 1 cycle later, rdata=0x1122334455667788;
//   strb=0x01 wdata=0xAA -> 0x11223344556677AA; read @0x1FFF -> rdata=0.
//  Same cycle: AXI write hit + vpu_wr_valid -> vpu_wr_ready=0, VPU accepted next cycle; data of both intact.
//  VPU size=11 addr=5, ch0 lane0=0x01..ch3 lane0=0x04 -> stream base=4 len=4 stride=1 yields lane0 0x04,0x03,0x02,0x01.
//  Stream base=DEPTH*CH_MAX-2 len=4 stride=1, str_ready toggling 1,0,1,... -> slots N-2,N-1,0,1, data stable on stall,
//   str_last on beat 4, str_done 1 cycle after its acceptance.
//  str_len=0 -> str_done next cycle, str_valid never high; str_start during RUN -> no effect.
//  rst_n low mid-stream (beat 2 of 8) -> outputs 0 immediately; after release, AXI read returns pre-reset data.

Source files
------------

// File: rtl/ubuf_stream_bank_if.sv
// Bus bundle for the unified-buffer bank: AXI word port, VPU slot-write port
// and the strided stream read port. slave = bank side, master = driver side.
interface ubuf_stream_bank_if #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 8,
  parameter int CH_MAX = 4,
  parameter int DEPTH  = 256,
  parameter int AXI_DW = 64,
  parameter int AXI_AW = 16
);
  localparam int SLOT_W = LANES * ELEM_W;
  localparam int SA_W   = $clog2(DEPTH * CH_MAX);

  logic                     axi_en;
  logic                     axi_we;
  logic [AXI_AW-1:0]        axi_addr;
  logic [AXI_DW-1:0]        axi_wdata;
  logic [AXI_DW/8-1:0]      axi_wstrb;
  logic [AXI_DW-1:0]        axi_rdata;
  logic                     axi_rvalid;

  logic                     vpu_wr_valid;
  logic                     vpu_wr_ready;
  logic [SA_W-1:0]          vpu_wr_addr;
  logic [1:0]               vpu_wr_size;
  logic [CH_MAX*SLOT_W-1:0] vpu_wr_data;

  logic                     str_start;
  logic [SA_W-1:0]          str_base;
  logic [15:0]              str_len;
  logic [SA_W-1:0]          str_stride;
  logic                     str_busy;
  logic                     str_done;
  logic                     str_valid;
  logic                     str_ready;
  logic [SLOT_W-1:0]        str_data;
  logic                     str_last;

  modport slave (
    input  axi_en, axi_we, axi_addr, axi_wdata, axi_wstrb,
    output axi_rdata, axi_rvalid,
    input  vpu_wr_valid, vpu_wr_addr, vpu_wr_size, vpu_wr_data,
    output vpu_wr_ready,
    input  str_start, str_base, str_len, str_stride, str_ready,
    output str_busy, str_done, str_valid, str_data, str_last
  );

  modport master (
    output axi_en, axi_we, axi_addr, axi_wdata, axi_wstrb,
    input  axi_rdata, axi_rvalid,
    output vpu_wr_valid, vpu_wr_addr, vpu_wr_size, vpu_wr_data,
    input  vpu_wr_ready,
    output str_start, str_base, str_len, str_stride, str_ready,
    input  str_busy, str_done, str_valid, str_data, str_last
  );
endinterface

// File: rtl/ubuf_stream_bank.sv
// Unified-buffer bank: DEPTH rows of CH_MAX slots. AXI byte-strobed word
// access, VPU multi-slot writes with backpressure, and a strided stream
// reader that emits one slot per beat under valid/ready.
module ubuf_stream_bank #(
  parameter int              LANES     = 16,
  parameter int              ELEM_W    = 8,
  parameter int              CH_MAX    = 4,
  parameter int              DEPTH     = 256,
  parameter int              AXI_DW    = 64,
  parameter int              AXI_AW    = 16,
  parameter logic [AXI_AW-1:0] BASE_ADDR = 16'h2000
) (
  input logic              clk,
  input logic              rst_n,
  ubuf_stream_bank_if.slave bus
);
  localparam int SLOT_W = LANES * ELEM_W;
  localparam int ROW_W  = CH_MAX * SLOT_W;
  localparam int WPR    = ROW_W / AXI_DW;
  localparam int SA_W   = $clog2(DEPTH * CH_MAX);
  localparam int CS_W   = $clog2(CH_MAX);
  localparam int RW     = $clog2(DEPTH);
  localparam int WW     = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int NBYTE  = AXI_DW / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [ROW_W-1:0] mem_q [DEPTH];

  // ---------------- AXI decode ----------------
  logic              axi_hit;
  logic [AXI_AW-1:0] axi_off;
  logic [RW-1:0]     axi_row;
  logic [WW-1:0]     axi_word;

  // Window check done in 32 bits so a bank near the top of the map cannot wrap.
  always_comb begin
    axi_off  = bus.axi_addr - BASE_ADDR;
    axi_hit  = (32'(bus.axi_addr) >= 32'(BASE_ADDR)) &&
               (32'(bus.axi_addr) <  32'(BASE_ADDR) + 32'(DEPTH * WPR));
    axi_row  = RW'(axi_off / AXI_AW'(WPR));
    axi_word = WW'(axi_off % AXI_AW'(WPR));
  end

  // ---------------- VPU decode ----------------
  logic                vpu_ready, vpu_fire;
  logic [2:0]          vn;
  logic [SA_W-1:0]     vbase;
  logic [RW-1:0]       vrow;
  logic [CS_W-1:0]     vs;
  logic [CH_MAX-1:0]   vslot_we;
  logic [ROW_W-1:0]    vrow_data;

  assign vpu_ready        = rst_n & ~(bus.axi_en & bus.axi_we & axi_hit);
  assign vpu_fire         = bus.vpu_wr_valid & vpu_ready;
  assign bus.vpu_wr_ready = vpu_ready;

  // Align the group to its size, then scatter channels in reverse slot order.
  always_comb begin
    vn    = 3'd0;
    vbase = bus.vpu_wr_addr;
    case (bus.vpu_wr_size)
      2'b01:   vn = 3'd1;
      2'b10:   begin vn = 3'd2; vbase[0]   = 1'b0;  end
      2'b11:   begin vn = 3'd4; vbase[1:0] = 2'b00; end
      default: vn = 3'd0;
    endcase
    vrow      = vbase[SA_W-1:CS_W];
    vs        = '0;
    vslot_we  = '0;
    vrow_data = '0;
    for (int c = 0; c < 4; c++) begin
      if (c < int'(vn)) begin
        vs = CS_W'(int'(vbase[CS_W-1:0]) + int'(vn) - 1 - c);
        vslot_we[vs] = 1'b1;
        vrow_data[vs*SLOT_W +: SLOT_W] = bus.vpu_wr_data[c*SLOT_W +: SLOT_W];
      end
    end
  end

  // Storage is not reset; an AXI write hit stalls the VPU so only one port writes.
  always_ff @(posedge clk) begin
    if (bus.axi_en && bus.axi_we && axi_hit)
      for (int b = 0; b < NBYTE; b++)
        if (bus.axi_wstrb[b])
          mem_q[axi_row][int'(axi_word)*AXI_DW + b*8 +: 8] <= bus.axi_wdata[b*8 +: 8];
    if (vpu_fire)
      for (int s = 0; s < CH_MAX; s++)
        if (vslot_we[s])
          mem_q[vrow][s*SLOT_W +: SLOT_W] <= vrow_data[s*SLOT_W +: SLOT_W];
  end

  // ---------------- AXI read ----------------
  logic [AXI_DW-1:0] rdata_q;
  logic              rvalid_q;

  // Registered read; a miss returns zero but still pulses rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.axi_en & ~bus.axi_we;
      if (bus.axi_en && !bus.axi_we)
        rdata_q <= axi_hit ? mem_q[axi_row][int'(axi_word)*AXI_DW +: AXI_DW] : '0;
    end
  end

  assign bus.axi_rdata  = rdata_q;
  assign bus.axi_rvalid = rvalid_q;

  // ---------------- Stream engine ----------------
  function automatic logic [SLOT_W-1:0] slot_rd(input logic [SA_W-1:0] sa);
    return mem_q[sa[SA_W-1:CS_W]][int'(sa[CS_W-1:0])*SLOT_W +: SLOT_W];
  endfunction

  logic [0:0]        state_q, state_d;
  logic [SA_W-1:0]   ptr_q, ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic [SLOT_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, last_q, last_d, done_q, done_d;

  // Next beat is fetched on acceptance so a ready consumer sees one beat per cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.str_start) begin
          if (bus.str_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            data_d  = slot_rd(bus.str_base);
            valid_d = 1'b1;
            last_d  = (bus.str_len == 16'd1);
            ptr_d   = bus.str_base + bus.str_stride;
            rem_d   = bus.str_len - 16'd1;
            state_d = S_RUN;
          end
        end
      end
      default: begin
        if (valid_q && bus.str_ready) begin
          if (rem_q != 16'd0) begin
            data_d = slot_rd(ptr_q);
            ptr_d  = ptr_q + bus.str_stride;
            rem_d  = rem_q - 16'd1;
            last_d = (rem_q == 16'd1);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // Stream state registers; reset abandons any stream in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.str_busy  = (state_q == S_RUN);
  assign bus.str_done  = done_q;
  assign bus.str_valid = valid_q;
  assign bus.str_data  = data_q;
  assign bus.str_last  = last_q;
endmodule

// File: tb/tb_ubuf_stream_bank.sv
// Self-checking bench for ubuf_stream_bank: AXI vector table, hand-written
// corner sequences, then randomized traffic against a byte-array model.
module tb_ubuf_stream_bank;
  localparam int LANES = 16, ELEM_W = 8, CH_MAX = 4, DEPTH = 256, AXI_DW = 64, AXI_AW = 16;
  localparam int NSLOT = DEPTH * CH_MAX;   // 1024 slots of 16 bytes
  localparam int NWORD = DEPTH * 8;        // 2048 AXI words of 8 bytes

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ubuf_stream_bank_if #(.LANES(LANES), .ELEM_W(ELEM_W), .CH_MAX(CH_MAX), .DEPTH(DEPTH),
                        .AXI_DW(AXI_DW), .AXI_AW(AXI_AW)) bus ();

  ubuf_stream_bank #(.LANES(LANES), .ELEM_W(ELEM_W), .CH_MAX(CH_MAX), .DEPTH(DEPTH),
                     .AXI_DW(AXI_DW), .AXI_AW(AXI_AW), .BASE_ADDR(16'h2000))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0;

  // Model: flat byte array. AXI word off covers bytes off*8..+7 (byte b at bits b*8);
  // slot sa covers bytes sa*16..+15, lane l is byte sa*16+15-l.
  logic [7:0] refm [NSLOT*16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit is_hit(input logic [15:0] a);
    return (a >= 16'h2000) && (a < 16'h2000 + 16'(NWORD));
  endfunction

  function automatic logic [63:0] ref_word(input int off);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = refm[off*8 + b];
    return w;
  endfunction

  function automatic logic [127:0] ref_slot(input int sa);
    logic [127:0] s;
    for (int j = 0; j < 16; j++) s[j*8 +: 8] = refm[sa*16 + j];
    return s;
  endfunction

  task automatic ref_axi_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] st);
    int off;
    off = int'(a) - 'h2000;
    for (int b = 0; b < 8; b++) if (st[b]) refm[off*8 + b] = d[b*8 +: 8];
  endtask

  task automatic ref_vpu_wr(input int addr, input logic [1:0] size, input logic [511:0] d);
    int n, base, sa;
    n = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : (size == 2'd3) ? 4 : 0;
    if (n == 0) return;
    base = (addr / n) * n;
    for (int c = 0; c < n; c++) begin
      sa = base + n - 1 - c;
      for (int j = 0; j < 16; j++) refm[sa*16 + j] = d[c*128 + j*8 +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.axi_en = 0; bus.axi_we = 0; bus.axi_addr = '0; bus.axi_wdata = '0; bus.axi_wstrb = '0;
    bus.vpu_wr_valid = 0; bus.vpu_wr_addr = '0; bus.vpu_wr_size = '0; bus.vpu_wr_data = '0;
    bus.str_start = 0; bus.str_base = '0; bus.str_len = '0; bus.str_stride = '0; bus.str_ready = 0;
  endtask

  task automatic axi_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] st);
    bus.axi_en = 1; bus.axi_we = 1; bus.axi_addr = a; bus.axi_wdata = d; bus.axi_wstrb = st;
    tick();
    bus.axi_en = 0; bus.axi_we = 0;
    if (is_hit(a)) ref_axi_wr(a, d, st);
  endtask

  task automatic axi_rd_chk(input string name, input logic [15:0] a, input logic [63:0] exp);
    bus.axi_en = 1; bus.axi_we = 0; bus.axi_addr = a;
    tick();
    bus.axi_en = 0;
    chk({name, "_rvalid"}, 128'(bus.axi_rvalid), 128'(1));
    chk(name, 128'(bus.axi_rdata), 128'(exp));
  endtask

  task automatic vpu_wr(input logic [9:0] a, input logic [1:0] size, input logic [511:0] d);
    bus.vpu_wr_valid = 1; bus.vpu_wr_addr = a; bus.vpu_wr_size = size; bus.vpu_wr_data = d;
    #1 chk("vpu_ready", 128'(bus.vpu_wr_ready), 128'(1));
    tick();
    bus.vpu_wr_valid = 0;
    ref_vpu_wr(int'(a), size, d);
  endtask

  // mode 0: ready always high, 1: toggle 1,0,1..., 2: random. poke: start pulse while running.
  task automatic run_stream(input string tag, input logic [9:0] base, input logic [15:0] len,
                            input logic [9:0] stride, input int mode, input bit poke);
    logic [127:0] expq [$];
    int beat, cyc;
    bit rdy;
    for (int i = 0; i < int'(len); i++)
      expq.push_back(ref_slot((int'(base) + i * int'(stride)) % NSLOT));
    bus.str_start = 1; bus.str_base = base; bus.str_len = len; bus.str_stride = stride;
    bus.str_ready = 0;
    tick();
    bus.str_start = 0;
    if (len == 16'd0) begin
      chk({tag, "_done0"}, 128'(bus.str_done), 128'(1));
      chk({tag, "_valid0"}, 128'(bus.str_valid), 128'(0));
      chk({tag, "_busy0"}, 128'(bus.str_busy), 128'(0));
      tick();
      chk({tag, "_done0_off"}, 128'(bus.str_done), 128'(0));
      chk({tag, "_valid0_off"}, 128'(bus.str_valid), 128'(0));
      return;
    end
    beat = 0;
    cyc  = 0;
    while (beat < int'(len) && cyc < 4 * int'(len) + 16) begin
      chk({tag, "_valid"}, 128'(bus.str_valid), 128'(1));
      chk({tag, "_busy"}, 128'(bus.str_busy), 128'(1));
      chk({tag, "_data"}, bus.str_data, expq[beat]);
      chk({tag, "_last"}, 128'(bus.str_last), 128'(beat == int'(len) - 1));
      chk({tag, "_done_run"}, 128'(bus.str_done), 128'(0));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      bus.str_ready = rdy;
      bus.str_start = poke && (cyc == 1);
      bus.str_base  = poke ? 10'd0 : base;
      bus.str_len   = poke ? 16'd1 : len;
      if (rdy) beat++;
      tick();
      cyc++;
    end
    bus.str_start = 0;
    chk({tag, "_beats"}, 128'(beat), 128'(len));
    chk({tag, "_done"}, 128'(bus.str_done), 128'(1));
    chk({tag, "_valid_end"}, 128'(bus.str_valid), 128'(0));
    chk({tag, "_busy_end"}, 128'(bus.str_busy), 128'(0));
    bus.str_ready = 0;
    tick();
    chk({tag, "_done_pulse"}, 128'(bus.str_done), 128'(0));
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp;
  } axi_vec_t;

  axi_vec_t tbl [14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] vd;
    logic [63:0]  wd, exp_rd;
    logic [15:0]  a;
    bit           do_axi, we, do_vpu, exp_rdy;
    logic [7:0]   st;
    logic [9:0]   va;
    logic [1:0]   vsz;

    tbl[0]  = '{1'b1, 16'h2000, 64'h1122334455667788, 8'hFF, 64'h0};
    tbl[1]  = '{1'b0, 16'h2000, 64'h0, 8'h00, 64'h1122334455667788};
    tbl[2]  = '{1'b1, 16'h2000, 64'h00000000000000AA, 8'h01, 64'h0};
    tbl[3]  = '{1'b0, 16'h2000, 64'h0, 8'h00, 64'h11223344556677AA};
    tbl[4]  = '{1'b0, 16'h1FFF, 64'h0, 8'h00, 64'h0};
    tbl[5]  = '{1'b1, 16'h2007, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
    tbl[6]  = '{1'b1, 16'h2007, 64'hFFFFFFFF00000000, 8'hF0, 64'h0};
    tbl[7]  = '{1'b0, 16'h2007, 64'h0, 8'h00, 64'hFFFFFFFF89ABCDEF};
    tbl[8]  = '{1'b1, 16'h27FF, 64'h0000000000005555, 8'hFF, 64'h0};
    tbl[9]  = '{1'b0, 16'h27FF, 64'h0, 8'h00, 64'h0000000000005555};
    tbl[10] = '{1'b1, 16'h2800, 64'h0000000000009999, 8'hFF, 64'h0};
    tbl[11] = '{1'b0, 16'h2800, 64'h0, 8'h00, 64'h0};
    tbl[12] = '{1'b0, 16'h2000, 64'h0, 8'h00, 64'h11223344556677AA};
    tbl[13] = '{1'b0, 16'h27FF, 64'h0, 8'h00, 64'h0000000000005555};

    idle_inputs();
    #1 rst_n = 0;
    #20;
    chk("rst_axi_rdata", 128'(bus.axi_rdata), 128'(0));
    chk("rst_axi_rvalid", 128'(bus.axi_rvalid), 128'(0));
    chk("rst_vpu_ready", 128'(bus.vpu_wr_ready), 128'(0));
    chk("rst_busy", 128'(bus.str_busy), 128'(0));
    chk("rst_done", 128'(bus.str_done), 128'(0));
    chk("rst_valid", 128'(bus.str_valid), 128'(0));
    chk("rst_last", 128'(bus.str_last), 128'(0));
    chk("rst_data", bus.str_data, 128'(0));
    rst_n = 1;
    tick();

    // AXI vector table
    foreach (tbl[i]) begin
      if (tbl[i].we) begin
        axi_wr(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
        chk("tbl_wr_rvalid", 128'(bus.axi_rvalid), 128'(0));
      end else begin
        axi_rd_chk("tbl_rd", tbl[i].addr, tbl[i].exp);
      end
    end
    tick();
    chk("rvalid_pulse_drop", 128'(bus.axi_rvalid), 128'(0));

    // Fill the whole bank so every later read has a known model value
    for (int off = 0; off < NWORD; off++)
      axi_wr(16'h2000 + 16'(off), {$urandom, $urandom}, 8'hFF);

    // AXI write hit blocks VPU for that cycle; VPU lands the next cycle
    vd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.axi_en = 1; bus.axi_we = 1; bus.axi_addr = 16'h2010;
    bus.axi_wdata = 64'hCAFEBABE_DEADBEEF; bus.axi_wstrb = 8'hFF;
    bus.vpu_wr_valid = 1; bus.vpu_wr_addr = 10'd41; bus.vpu_wr_size = 2'b10; bus.vpu_wr_data = vd;
    #1 chk("coll_vpu_blocked", 128'(bus.vpu_wr_ready), 128'(0));
    tick();
    ref_axi_wr(16'h2010, 64'hCAFEBABE_DEADBEEF, 8'hFF);
    bus.axi_en = 0; bus.axi_we = 0;
    #1 chk("coll_vpu_ready", 128'(bus.vpu_wr_ready), 128'(1));
    tick();
    bus.vpu_wr_valid = 0;
    ref_vpu_wr(41, 2'b10, vd);
    axi_rd_chk("coll_axi_data", 16'h2010, 64'hCAFEBABE_DEADBEEF);
    axi_rd_chk("coll_vpu_word", 16'h2050, ref_word(16'h50));
    run_stream("coll_stream", 10'd40, 16'd2, 10'd1, 0, 1'b0);

    // 4-slot VPU write, channel c lane0 = c+1, reversed into slots 4..7
    vd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 4; c++) vd[c*128 + 120 +: 8] = 8'(c + 1);
    vpu_wr(10'd5, 2'b11, vd);
    axi_rd_chk("vpu4_slot4", 16'h2009, {8'h04, ref_word(9)[55:0]});
    axi_rd_chk("vpu4_slot5", 16'h200B, {8'h03, ref_word(11)[55:0]});
    axi_rd_chk("vpu4_slot6", 16'h200D, {8'h02, ref_word(13)[55:0]});
    axi_rd_chk("vpu4_slot7", 16'h200F, {8'h01, ref_word(15)[55:0]});
    run_stream("vpu4_stream", 10'd4, 16'd4, 10'd1, 0, 1'b0);

    // Size 00 handshakes but writes nothing
    wd = ref_word(16'h40);
    vpu_wr(10'd32, 2'b00, ~vd);
    axi_rd_chk("vpu_size0", 16'h2040, wd);

    // Wrap around the slot space with a stalling consumer
    run_stream("wrap", 10'(NSLOT - 2), 16'd4, 10'd1, 1, 1'b0);
    run_stream("len0", 10'd10, 16'd0, 10'd1, 0, 1'b0);
    run_stream("poke", 10'd200, 16'd5, 10'd7, 0, 1'b1);

    // Reset in the middle of a stream
    bus.str_start = 1; bus.str_base = 10'd100; bus.str_len = 16'd8; bus.str_stride = 10'd3;
    tick();
    bus.str_start = 0; bus.str_ready = 1;
    tick();
    chk("mid_beat2", bus.str_data, ref_slot(103));
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 128'(bus.str_valid), 128'(0));
    chk("mid_rst_busy", 128'(bus.str_busy), 128'(0));
    chk("mid_rst_data", bus.str_data, 128'(0));
    chk("mid_rst_vpu_ready", 128'(bus.vpu_wr_ready), 128'(0));
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("mid_after_valid", 128'(bus.str_valid), 128'(0));
    chk("mid_after_busy", 128'(bus.str_busy), 128'(0));
    bus.str_ready = 0;
    axi_rd_chk("mid_mem_kept", 16'h2010, 64'hCAFEBABE_DEADBEEF);
    run_stream("mid_restart", 10'd100, 16'd3, 10'd3, 0, 1'b0);

    // Randomized traffic rounds, each followed by a random stream
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 40; k++) begin
        do_axi = 1'($urandom); we = 1'($urandom); do_vpu = 1'($urandom);
        a  = 16'($urandom_range(16'h1FF8, 16'h2807));
        wd = {$urandom, $urandom};
        st = 8'($urandom);
        va = 10'($urandom);
        vsz = 2'($urandom);
        vd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.axi_en = do_axi; bus.axi_we = we; bus.axi_addr = a; bus.axi_wdata = wd; bus.axi_wstrb = st;
        bus.vpu_wr_valid = do_vpu; bus.vpu_wr_addr = va; bus.vpu_wr_size = vsz; bus.vpu_wr_data = vd;
        exp_rdy = !(do_axi && we && is_hit(a));
        exp_rd  = is_hit(a) ? ref_word(int'(a) - 'h2000) : 64'h0;
        #1 chk("rnd_vpu_ready", 128'(bus.vpu_wr_ready), 128'(exp_rdy));
        tick();
        if (do_axi && !we) begin
          chk("rnd_rvalid", 128'(bus.axi_rvalid), 128'(1));
          chk("rnd_rdata", 128'(bus.axi_rdata), 128'(exp_rd));
        end else begin
          chk("rnd_rvalid_idle", 128'(bus.axi_rvalid), 128'(0));
        end
        if (do_axi && we && is_hit(a)) ref_axi_wr(a, wd, st);
        if (do_vpu && exp_rdy) ref_vpu_wr(int'(va), vsz, vd);
      end
      idle_inputs();
      tick();
      run_stream("rnd_stream", 10'($urandom), 16'($urandom_range(0, 10)), 10'($urandom), 2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
